ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes scan-code set 2 bytes from the ps2_kbd FIFO over its read/ready interface.
//  Decodes E0 (extended) and F0 (break) prefixes and tracks Shift/Ctrl/CapsLock state.
//  Emits one key event per make code, carrying the ASCII value, over a valid/ack handshake.
//  The consumer is the CPU keyboard MMIO register.
// PARAMETERS
//  REPEAT_EN      1  1: every typematic repeat make emits an event; 0: repeats of held key dropped
//  EMIT_UNMAPPED  1  1: makes with no ASCII mapping emit an event with ascii=0; 0: silently dropped
// PORTS
//  clk        in   1  system clock, all state on posedge
//  clrn       in   1  asynchronous active-low reset
//  kbd_data   in   8  ps2_kbd.data (head of FIFO)
//  kbd_ready  in   1  ps2_kbd.ready (FIFO non-empty)
//  kbd_read   out  1  one-cycle pop strobe to ps2_kbd.read
//  out_valid  out  1  key event available
//  out_ascii  out  8  ASCII of event (0 if unmapped)
//  out_code   out  8  raw make code of event
//  out_ext    out  1  event code was E0-prefixed
//  out_ctrl   out  1  a Ctrl key was held when the event was decoded
//  out_ack    in   1  consumer takes event this cycle (ignored when out_valid=0)
//  caps_lock  out  1  CapsLock toggle state, for LED
// BEHAVIOUR
//  Reset (async, clrn=0):
//   - kbd_read, out_valid, out_ascii, out_code, out_ext, out_ctrl and caps_lock are 0.
//   - Modifier flags and last_make are 0; FSM is in IDLE.
//   - A byte being consumed at the moment of reset is lost; decoding restarts clean.
//  Pop rule:
//   - kbd_read=1 iff kbd_ready & ~pop_d & (~out_valid | out_ack); pop_d is kbd_read delayed one cycle.
//   - kbd_read is therefore never high on two consecutive cycles.
//   - The byte is taken from kbd_data in the same cycle as kbd_read=1.
//   - The next cycle is skipped so that ps2_kbd ready/data can update.
//  FSM (advances only on a popped byte):
//   - IDLE:    E0 -> EXT; F0 -> BRK; otherwise -> MAKE(ext=0), stay IDLE.
//   - EXT:     F0 -> EXTBRK; E0 -> EXT; otherwise -> MAKE(ext=1), then IDLE.
//   - BRK:     any byte -> BREAK(ext=0), then IDLE.
//   - EXTBRK:  any byte -> BREAK(ext=1), then IDLE.
//   - Byte E1 or AA in IDLE: discarded, state unchanged.
//  Modifiers:
//   - Shift: 12 and 59 set/clear lshift/rshift on MAKE/BREAK.
//   - Ctrl: 14 (ext=0 and ext=1) sets/clears ctrl on MAKE/BREAK.
//   - CapsLock: 58 toggles caps_lock on MAKE only. Suppressed when 58 equals last_make, so typematic never re-toggles.
//   - Modifiers never emit events.
//  MAKE of a non-modifier:
//   - ASCII mapping, ext=0 only:
//     - letters 'a'..'z'; uppercase iff shift XOR caps_lock.
//     - digits 16,1E,26,25,2E,36,3D,3E,46,45 -> '1'..'9','0'; with shift -> !@#$%^&*().
//     - 29 -> 20 (space), 5A -> 0D, 66 -> 08, 0D -> 09, 76 -> 1B.
//     - 4E, 55, 41, 49, 4A -> - = , . / (shifted _ + < > ?).
//   - All ext=1 codes are unmapped.
//   - If REPEAT_EN=0 and {ext,code}==last_make: no event.
//   - Else if the code is mapped or EMIT_UNMAPPED=1: out_* are loaded and out_valid=1 on the cycle after kbd_read.
//   - last_make is set to {ext,code}.
//  BREAK clears last_make if it matches {ext,code}.
//  out_valid and all out_* stay stable until the out_ack cycle. out_valid drops the next cycle unless a new event loads in the same edge.
//  Bytes are only popped when the output slot is free, so no event is ever overwritten or lost. Backpressure stalls ps2_kbd; its overflow flag is not this block's concern.
// TESTING
//  - Pop 1C -> one kbd_read pulse; next cycle out_valid=1, out_ascii=61, out_code=1C, out_ext=0.
//  - 12,1C,F0,1C,F0,12 -> exactly one event, ascii=41. After that, 1C -> ascii=61 (shift released).
//  - 58,F0,58,1C -> caps_lock=1 and ascii=41. Then 12,1C -> ascii=61 (shift XOR caps).
//  - E0,75,E0,F0,75 with EMIT_UNMAPPED=1 -> one event: code=75, ext=1, ascii=00. With EMIT_UNMAPPED=0 -> no event.
//  - out_ack held 0 while 4 bytes are queued -> kbd_read stays 0 after the first event. Each out_ack releases exactly one pop; no two consecutive kbd_read cycles.
//  - REPEAT_EN=0: 1C,1C,1C,F0,1C,1C -> 2 events. clrn pulsed low mid-sequence after F0 -> next 1C gives a MAKE event.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: pops bytes from the ps2_kbd FIFO, resolves E0/F0 prefixes,
// tracks Shift/Ctrl/CapsLock and presents one ASCII key event per make code on a valid/ack slot.
module ps2_scancode_decoder #(
    parameter bit REPEAT_EN     = 1'b1,
    parameter bit EMIT_UNMAPPED = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_read,
    output logic       out_valid,
    output logic [7:0] out_ascii,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_ctrl,
    input  logic       out_ack,
    output logic       caps_lock
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} state_t;

    state_t     state_r, state_s;
    logic       pop_d_r;
    logic       lshift_r, rshift_r, ctrl_r, caps_r;
    logic [8:0] last_make_r;
    logic       out_valid_r, out_ext_r, out_ctrl_r;
    logic [7:0] out_ascii_r, out_code_r;

    logic       kbd_read_s, make_s, brk_s, ext_s;
    logic       is_shift_s, is_ctrl_s, is_caps_s, is_mod_s, mapped_s, emit_s;
    logic [8:0] key_s, map_s;

    // Returns {mapped, ascii}; letters follow shift^caps, everything else follows shift only.
    function automatic logic [8:0] ascii_map(input logic [7:0] code, input logic shift, input logic caps);
        logic [7:0] letter, plain, shifted;
        logic       hit;
        logic [8:0] result;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;  8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;  8'h34: letter = 8'h67;  8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;  8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;  8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;  8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;  8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            default: letter = 8'h00;
        endcase
        hit = 1'b1;
        case (code)
            8'h16: begin plain = 8'h31; shifted = 8'h21; end
            8'h1E: begin plain = 8'h32; shifted = 8'h40; end
            8'h26: begin plain = 8'h33; shifted = 8'h23; end
            8'h25: begin plain = 8'h34; shifted = 8'h24; end
            8'h2E: begin plain = 8'h35; shifted = 8'h25; end
            8'h36: begin plain = 8'h36; shifted = 8'h5E; end
            8'h3D: begin plain = 8'h37; shifted = 8'h26; end
            8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
            8'h46: begin plain = 8'h39; shifted = 8'h28; end
            8'h45: begin plain = 8'h30; shifted = 8'h29; end
            8'h29: begin plain = 8'h20; shifted = 8'h20; end
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end
            8'h55: begin plain = 8'h3D; shifted = 8'h2B; end
            8'h41: begin plain = 8'h2C; shifted = 8'h3C; end
            8'h49: begin plain = 8'h2E; shifted = 8'h3E; end
            8'h4A: begin plain = 8'h2F; shifted = 8'h3F; end
            default: begin plain = 8'h00; shifted = 8'h00; hit = 1'b0; end
        endcase
        if (letter != 8'h00) begin
            result = {1'b1, ((shift ^ caps) ? (letter - 8'h20) : letter)};
        end else if (hit) begin
            result = {1'b1, (shift ? shifted : plain)};
        end else begin
            result = 9'h000;
        end
        return result;
    endfunction

    // The skipped cycle after each pop gives ps2_kbd time to present its next byte.
    assign kbd_read_s = clrn & kbd_ready & ~pop_d_r & (~out_valid_r | out_ack);

    // Prefix FSM next state and classification of the popped byte.
    always_comb begin
        state_s = state_r;
        make_s  = 1'b0;
        brk_s   = 1'b0;
        ext_s   = 1'b0;
        if (kbd_read_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (kbd_data == 8'hE0) begin
                        state_s = ST_EXT;
                    end else if (kbd_data == 8'hF0) begin
                        state_s = ST_BRK;
                    end else if ((kbd_data == 8'hE1) || (kbd_data == 8'hAA)) begin
                        state_s = ST_IDLE;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (kbd_data == 8'hF0) begin
                        state_s = ST_EXTBRK;
                    end else if (kbd_data == 8'hE0) begin
                        state_s = ST_EXT;
                    end else begin
                        make_s  = 1'b1;
                        ext_s   = 1'b1;
                        state_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_s   = 1'b1;
                    state_s = ST_IDLE;
                end
                ST_EXTBRK: begin
                    brk_s   = 1'b1;
                    ext_s   = 1'b1;
                    state_s = ST_IDLE;
                end
                default: state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Modifier recognition, ASCII lookup and the emit decision for the popped byte.
    always_comb begin
        key_s      = {ext_s, kbd_data};
        is_shift_s = ~ext_s & ((kbd_data == 8'h12) | (kbd_data == 8'h59));
        is_ctrl_s  = (kbd_data == 8'h14);
        is_caps_s  = ~ext_s & (kbd_data == 8'h58);
        is_mod_s   = is_shift_s | is_ctrl_s | is_caps_s;
        map_s      = ascii_map(kbd_data, lshift_r | rshift_r, caps_r);
        mapped_s   = ~ext_s & map_s[8];
        emit_s     = make_s & ~is_mod_s & (REPEAT_EN | (key_s != last_make_r)) & (mapped_s | EMIT_UNMAPPED);
    end

    // Pop history and FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pop_d_r <= 1'b0;
            state_r <= ST_IDLE;
        end else begin
            pop_d_r <= kbd_read_s;
            state_r <= state_s;
        end
    end

    // Modifier flags and last make; CapsLock ignores typematic repeats of itself.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lshift_r    <= 1'b0;
            rshift_r    <= 1'b0;
            ctrl_r      <= 1'b0;
            caps_r      <= 1'b0;
            last_make_r <= 9'h000;
        end else if (make_s | brk_s) begin
            if (is_shift_s && (kbd_data == 8'h12)) lshift_r <= make_s;
            if (is_shift_s && (kbd_data == 8'h59)) rshift_r <= make_s;
            if (is_ctrl_s) ctrl_r <= make_s;
            if (make_s && is_caps_s && (key_s != last_make_r)) caps_r <= ~caps_r;
            if (make_s) begin
                last_make_r <= key_s;
            end else if (key_s == last_make_r) begin
                last_make_r <= 9'h000;
            end
        end
    end

    // Output slot: loads on emit, otherwise held until acknowledged.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid_r <= 1'b0;
            out_ascii_r <= 8'h00;
            out_code_r  <= 8'h00;
            out_ext_r   <= 1'b0;
            out_ctrl_r  <= 1'b0;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            out_ascii_r <= mapped_s ? map_s[7:0] : 8'h00;
            out_code_r  <= kbd_data;
            out_ext_r   <= ext_s;
            out_ctrl_r  <= ctrl_r;
        end else if (out_ack) begin
            out_valid_r <= 1'b0;
        end
    end

    assign kbd_read  = kbd_read_s;
    assign out_valid = out_valid_r;
    assign out_ascii = out_ascii_r;
    assign out_code  = out_code_r;
    assign out_ext   = out_ext_r;
    assign out_ctrl  = out_ctrl_r;
    assign caps_lock = caps_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench: two decoders (default parameters, and REPEAT_EN=0/EMIT_UNMAPPED=0)
// each fed from its own FIFO model; expected events are queued with the stimulus.
module tb_ps2_scancode_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clrn;
    logic [7:0] kbd_data_a, kbd_data_b, out_ascii_a, out_ascii_b, out_code_a, out_code_b;
    logic       kbd_ready_a, kbd_ready_b, kbd_read_a, kbd_read_b, out_valid_a, out_valid_b;
    logic       out_ext_a, out_ext_b, out_ctrl_a, out_ctrl_b, out_ack_a, out_ack_b;
    logic       caps_lock_a, caps_lock_b;

    logic [7:0]  fifo_a[$], fifo_b[$];
    logic [17:0] sb_a[$], sb_b[$];
    logic [17:0] exp_ev;
    int          credits_a, credits_b;
    logic        popped_a, popped_b, ov_prev_a, ov_prev_b;
    int          n_checks = 0;
    int          n_errors = 0;

    ps2_scancode_decoder dut_a (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data_a), .kbd_ready(kbd_ready_a), .kbd_read(kbd_read_a),
        .out_valid(out_valid_a), .out_ascii(out_ascii_a), .out_code(out_code_a), .out_ext(out_ext_a),
        .out_ctrl(out_ctrl_a), .out_ack(out_ack_a), .caps_lock(caps_lock_a)
    );

    ps2_scancode_decoder #(.REPEAT_EN(1'b0), .EMIT_UNMAPPED(1'b0)) dut_b (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data_b), .kbd_ready(kbd_ready_b), .kbd_read(kbd_read_b),
        .out_valid(out_valid_b), .out_ascii(out_ascii_b), .out_code(out_code_b), .out_ext(out_ext_b),
        .out_ctrl(out_ctrl_b), .out_ack(out_ack_b), .caps_lock(caps_lock_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [17:0] ev(input logic [7:0] a, input logic [7:0] c, input logic e, input logic k);
        return {a, c, e, k};
    endfunction

    task automatic put_a(input logic [7:0] b); fifo_a.push_back(b); endtask
    task automatic put_b(input logic [7:0] b); fifo_b.push_back(b); endtask

    // FIFO models pop on the edge where kbd_read is high.
    always @(posedge clk) begin
        popped_a = kbd_read_a;
        popped_b = kbd_read_b;
        if (kbd_read_a && fifo_a.size() > 0) void'(fifo_a.pop_front());
        if (kbd_read_b && fifo_b.size() > 0) void'(fifo_b.pop_front());
    end

    // Consumer and protocol monitor; also refreshes FIFO head for the next cycle.
    always @(negedge clk) begin
        if (out_valid_a && !ov_prev_a) check("a_latency", 32'(popped_a), 32'd1);
        if (out_valid_b && !ov_prev_b) check("b_latency", 32'(popped_b), 32'd1);
        if (popped_a) check("a_read_gap", 32'(kbd_read_a), 32'd0);
        if (popped_b) check("b_read_gap", 32'(kbd_read_b), 32'd0);
        ov_prev_a = out_valid_a;
        ov_prev_b = out_valid_b;
        if (out_valid_a && credits_a > 0) begin
            check("a_event_expected", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) begin
                exp_ev = sb_a.pop_front();
                check("a_event", 32'({out_ascii_a, out_code_a, out_ext_a, out_ctrl_a}), 32'(exp_ev));
            end
            out_ack_a = 1'b1;
            credits_a--;
        end else begin
            out_ack_a = 1'b0;
        end
        if (out_valid_b && credits_b > 0) begin
            check("b_event_expected", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) begin
                exp_ev = sb_b.pop_front();
                check("b_event", 32'({out_ascii_b, out_code_b, out_ext_b, out_ctrl_b}), 32'(exp_ev));
            end
            out_ack_b = 1'b1;
            credits_b--;
        end else begin
            out_ack_b = 1'b0;
        end
        kbd_ready_a = (fifo_a.size() != 0);
        kbd_data_a  = kbd_ready_a ? fifo_a[0] : 8'h00;
        kbd_ready_b = (fifo_b.size() != 0);
        kbd_data_b  = kbd_ready_b ? fifo_b[0] : 8'h00;
    end

    task automatic wait_idle(input string tag);
        logic busy;
        busy = 1'b1;
        for (int i = 0; i < 400 && busy; i++) begin
            @(negedge clk);
            busy = (fifo_a.size() != 0) || (sb_a.size() != 0) || out_valid_a ||
                   (fifo_b.size() != 0) || (sb_b.size() != 0) || out_valid_b;
        end
        repeat (4) @(negedge clk);
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0;
        kbd_data_a = 8'h00; kbd_data_b = 8'h00; kbd_ready_a = 1'b0; kbd_ready_b = 1'b0;
        out_ack_a = 1'b0; out_ack_b = 1'b0;
        credits_a = 1000000; credits_b = 1000000;
        popped_a = 1'b0; popped_b = 1'b0; ov_prev_a = 1'b0; ov_prev_b = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset", 32'({kbd_read_a, out_valid_a, out_ascii_a, out_code_a, out_ext_a, out_ctrl_a, caps_lock_a}), 32'd0);
        check("b_reset", 32'({kbd_read_b, out_valid_b, out_ascii_b, out_code_b, out_ext_b, out_ctrl_b, caps_lock_b}), 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // plain letter
        put_a(8'h1C); sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0)); put_a(8'hF0); put_a(8'h1C);
        wait_idle("a_drain_letter");
        // shifted letter, then shift released
        put_a(8'h12); put_a(8'h1C); put_a(8'hF0); put_a(8'h1C); put_a(8'hF0); put_a(8'h12);
        sb_a.push_back(ev(8'h41, 8'h1C, 1'b0, 1'b0));
        put_a(8'h1C); sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0)); put_a(8'hF0); put_a(8'h1C);
        wait_idle("a_drain_shift");
        // CapsLock, then shift XOR caps
        put_a(8'h58); put_a(8'hF0); put_a(8'h58); put_a(8'h1C); sb_a.push_back(ev(8'h41, 8'h1C, 1'b0, 1'b0));
        put_a(8'hF0); put_a(8'h1C);
        wait_idle("a_drain_caps");
        check("a_caps_on", 32'(caps_lock_a), 32'd1);
        put_a(8'h12); put_a(8'h1C); sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0));
        put_a(8'hF0); put_a(8'h1C); put_a(8'hF0); put_a(8'h12);
        // typematic CapsLock toggles once only
        put_a(8'h58); put_a(8'h58); put_a(8'hF0); put_a(8'h58);
        wait_idle("a_drain_caps_rep");
        check("a_caps_off", 32'(caps_lock_a), 32'd0);
        // extended make/break, unmapped
        put_a(8'hE0); put_a(8'h75); put_a(8'hE0); put_a(8'hF0); put_a(8'h75);
        sb_a.push_back(ev(8'h00, 8'h75, 1'b1, 1'b0));
        // shifted digit, punctuation, space, unmapped plain code, AA discarded
        put_a(8'h12); put_a(8'h16); put_a(8'hF0); put_a(8'h16); put_a(8'hF0); put_a(8'h12);
        sb_a.push_back(ev(8'h21, 8'h16, 1'b0, 1'b0));
        put_a(8'h4E); sb_a.push_back(ev(8'h2D, 8'h4E, 1'b0, 1'b0));
        put_a(8'h29); sb_a.push_back(ev(8'h20, 8'h29, 1'b0, 1'b0));
        put_a(8'h05); sb_a.push_back(ev(8'h00, 8'h05, 1'b0, 1'b0));
        put_a(8'hAA); put_a(8'h1C); sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0));
        // Ctrl, both plain and E0-prefixed; repeat emits with REPEAT_EN=1
        put_a(8'h14); put_a(8'h21); put_a(8'hF0); put_a(8'h21); put_a(8'hF0); put_a(8'h14);
        sb_a.push_back(ev(8'h63, 8'h21, 1'b0, 1'b1));
        put_a(8'hE0); put_a(8'h14); put_a(8'h1C); put_a(8'hE0); put_a(8'hF0); put_a(8'h14);
        sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b1));
        put_a(8'h1C); put_a(8'h1C); put_a(8'hF0); put_a(8'h1C);
        sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0)); sb_a.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0));
        wait_idle("a_drain_mixed");

        // backpressure: no acks while four bytes wait
        credits_a = 0;
        put_a(8'h32); put_a(8'h21); put_a(8'h23); put_a(8'h24);
        sb_a.push_back(ev(8'h62, 8'h32, 1'b0, 1'b0)); sb_a.push_back(ev(8'h63, 8'h21, 1'b0, 1'b0));
        sb_a.push_back(ev(8'h64, 8'h23, 1'b0, 1'b0)); sb_a.push_back(ev(8'h65, 8'h24, 1'b0, 1'b0));
        repeat (20) @(negedge clk);
        check("a_bp_fifo", 32'(fifo_a.size()), 32'd3);
        check("a_bp_hold", 32'({out_valid_a, out_code_a}), 32'h132);
        credits_a = 1;
        repeat (10) @(negedge clk);
        check("a_bp_one_pop", 32'(fifo_a.size()), 32'd2);
        check("a_bp_next", 32'({out_valid_a, out_code_a}), 32'h121);
        credits_a = 1000000;
        wait_idle("a_drain_bp");

        // REPEAT_EN=0 / EMIT_UNMAPPED=0 instance
        put_b(8'hE0); put_b(8'h75); put_b(8'hE0); put_b(8'hF0); put_b(8'h75); put_b(8'h05);
        put_b(8'h1C); put_b(8'h1C); put_b(8'h1C); put_b(8'hF0); put_b(8'h1C); put_b(8'h1C);
        sb_b.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0)); sb_b.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0));
        put_b(8'h58); put_b(8'h1C); sb_b.push_back(ev(8'h41, 8'h1C, 1'b0, 1'b0)); put_b(8'hF0);
        wait_idle("b_drain_repeat");
        check("b_caps_on", 32'(caps_lock_b), 32'd1);
        // reset mid-sequence (after F0) with a byte already waiting
        clrn = 1'b0;
        put_b(8'h1C); sb_b.push_back(ev(8'h61, 8'h1C, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        check("b_reset_mid", 32'({kbd_ready_b, kbd_read_b, out_valid_b, caps_lock_b}), 32'h8);
        clrn = 1'b1;
        wait_idle("b_drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
